// File: rtl/muldiv_pkg.sv
// Shared encodings for the multi-cycle multiply/divide unit.
// Holds the op codes and the sequencer state type.
package muldiv_pkg;

    localparam logic [1:0] OP_MULT = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_MTHI = 2'b10;
    localparam logic [1:0] OP_MTLO = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DIV  = 2'b10,
        FIX  = 2'b11
    } state_t;

endpackage

// File: rtl/div_iter.sv
// Radix-2 restoring divider core on unsigned magnitudes.
// Produces one quotient bit per step; the caller sequences WIDTH steps.
module div_iter
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] dvs_r;
    logic [WIDTH:0]   shifted_s;
    logic [WIDTH:0]   diff_s;

    // Trial subtraction of the divisor from the partial remainder with the next dividend bit.
    always_comb begin
        shifted_s = {rem_r, quo_r[WIDTH-1]};
        diff_s    = shifted_s - {1'b0, dvs_r};
    end

    // Partial remainder / quotient shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            quo_r <= {WIDTH{1'b0}};
            rem_r <= {WIDTH{1'b0}};
            dvs_r <= {WIDTH{1'b0}};
        end else if (load) begin
            quo_r <= dividend;
            rem_r <= {WIDTH{1'b0}};
            dvs_r <= divisor;
        end else if (step) begin
            // The remainder stays below the divisor, so the trial value never exceeds WIDTH+1 bits.
            if (!diff_s[WIDTH]) begin
                rem_r <= diff_s[WIDTH-1:0];
                quo_r <= {quo_r[WIDTH-2:0], 1'b1};
            end else begin
                rem_r <= shifted_s[WIDTH-1:0];
                quo_r <= {quo_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            quo_r <= quo_r;
            rem_r <= rem_r;
            dvs_r <= dvs_r;
        end
    end

    assign quotient  = quo_r;
    assign remainder = rem_r;

endmodule

// File: rtl/muldiv.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Multiplies use a retimeable product delay line; divides use div_iter plus a sign-fix cycle.
module muldiv
    import muldiv_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             hassign,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH + MUL_CYCLES + 1);

    state_t             state_r, state_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic [WIDTH-1:0]   hi_r, hi_s, lo_r, lo_s;
    logic               busy_r, busy_s, done_r, done_s;
    logic               latch_s, load_s, step_s;
    logic [WIDTH-1:0]   a_r, b_r;
    logic               sgn_r, neg_q_r, neg_rem_r;
    logic [WIDTH-1:0]   mag_a_s, mag_b_s;
    logic [WIDTH-1:0]   quo_s, rem_s, fix_lo_s, fix_hi_s;
    logic [2*WIDTH-1:0] prod_s, mul_res_s;

    // Operand magnitudes for the unsigned divider core.
    always_comb begin
        if (hassign && srca[WIDTH-1]) begin
            mag_a_s = {WIDTH{1'b0}} - srca;
        end else begin
            mag_a_s = srca;
        end
        if (hassign && srcb[WIDTH-1]) begin
            mag_b_s = {WIDTH{1'b0}} - srcb;
        end else begin
            mag_b_s = srcb;
        end
    end

    // Operand and result-sign capture at request acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r       <= {WIDTH{1'b0}};
            b_r       <= {WIDTH{1'b0}};
            sgn_r     <= 1'b0;
            neg_q_r   <= 1'b0;
            neg_rem_r <= 1'b0;
        end else if (latch_s) begin
            a_r       <= srca;
            b_r       <= srcb;
            sgn_r     <= hassign;
            neg_q_r   <= hassign & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
            neg_rem_r <= hassign & srca[WIDTH-1];
        end else begin
            a_r       <= a_r;
            b_r       <= b_r;
            sgn_r     <= sgn_r;
            neg_q_r   <= neg_q_r;
            neg_rem_r <= neg_rem_r;
        end
    end

    // Sign-extending to 2*WIDTH makes one unsigned multiply serve both signednesses.
    assign prod_s = {{WIDTH{sgn_r & a_r[WIDTH-1]}}, a_r} * {{WIDTH{sgn_r & b_r[WIDTH-1]}}, b_r};

    if (MUL_CYCLES > 1) begin : g_mul_pipe
        logic [2*WIDTH-1:0] pipe_r [MUL_CYCLES-1];

        // Product delay line; synthesis may retime the multiplier into it.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < MUL_CYCLES - 1; i++) begin
                    pipe_r[i] <= {(2*WIDTH){1'b0}};
                end
            end else begin
                pipe_r[0] <= prod_s;
                for (int i = 1; i < MUL_CYCLES - 1; i++) begin
                    pipe_r[i] <= pipe_r[i-1];
                end
            end
        end

        assign mul_res_s = pipe_r[MUL_CYCLES-2];
    end else begin : g_mul_comb
        assign mul_res_s = prod_s;
    end

    div_iter #(.WIDTH(WIDTH)) u_div_iter (
        .clk       (clk),
        .rst       (rst),
        .load      (load_s),
        .step      (step_s),
        .dividend  (mag_a_s),
        .divisor   (mag_b_s),
        .quotient  (quo_s),
        .remainder (rem_s)
    );

    // Final divide result: special cases, then sign restoration.
    always_comb begin
        if (b_r == {WIDTH{1'b0}}) begin
            fix_lo_s = {WIDTH{1'b1}};
            fix_hi_s = a_r;
        end else if (sgn_r && (a_r == {1'b1, {(WIDTH-1){1'b0}}}) && (b_r == {WIDTH{1'b1}})) begin
            fix_lo_s = {1'b1, {(WIDTH-1){1'b0}}};
            fix_hi_s = {WIDTH{1'b0}};
        end else begin
            fix_lo_s = neg_q_r   ? ({WIDTH{1'b0}} - quo_s) : quo_s;
            fix_hi_s = neg_rem_r ? ({WIDTH{1'b0}} - rem_s) : rem_s;
        end
    end

    // Sequencer next-state and register-update logic.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        hi_s    = hi_r;
        lo_s    = lo_r;
        busy_s  = busy_r;
        done_s  = 1'b0;
        latch_s = 1'b0;
        load_s  = 1'b0;
        step_s  = 1'b0;
        case (state_r)
            IDLE: begin
                busy_s = 1'b0;
                if (start && !cancel) begin
                    case (op)
                        OP_MTHI: begin
                            hi_s   = srca;
                            done_s = 1'b1;
                        end
                        OP_MTLO: begin
                            lo_s   = srca;
                            done_s = 1'b1;
                        end
                        OP_MULT: begin
                            latch_s = 1'b1;
                            state_s = MUL;
                            cnt_s   = CNT_W'(MUL_CYCLES - 1);
                            busy_s  = 1'b1;
                        end
                        OP_DIV: begin
                            latch_s = 1'b1;
                            load_s  = 1'b1;
                            state_s = DIV;
                            cnt_s   = CNT_W'(WIDTH - 1);
                            busy_s  = 1'b1;
                        end
                        default: begin
                            state_s = IDLE;
                        end
                    endcase
                end else begin
                    state_s = IDLE;
                end
            end
            MUL: begin
                if (cancel) begin
                    state_s = IDLE;
                    cnt_s   = {CNT_W{1'b0}};
                    busy_s  = 1'b0;
                end else if (cnt_r == {CNT_W{1'b0}}) begin
                    hi_s    = mul_res_s[2*WIDTH-1:WIDTH];
                    lo_s    = mul_res_s[WIDTH-1:0];
                    state_s = IDLE;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                end else begin
                    cnt_s = cnt_r - CNT_W'(1);
                end
            end
            DIV: begin
                if (cancel) begin
                    state_s = IDLE;
                    cnt_s   = {CNT_W{1'b0}};
                    busy_s  = 1'b0;
                end else begin
                    step_s = 1'b1;
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        state_s = FIX;
                    end else begin
                        cnt_s = cnt_r - CNT_W'(1);
                    end
                end
            end
            FIX: begin
                state_s = IDLE;
                cnt_s   = {CNT_W{1'b0}};
                busy_s  = 1'b0;
                if (!cancel) begin
                    hi_s   = fix_hi_s;
                    lo_s   = fix_lo_s;
                    done_s = 1'b1;
                end else begin
                    done_s = 1'b0;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = {CNT_W{1'b0}};
                busy_s  = 1'b0;
            end
        endcase
    end

    // State, counter and architectural output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            hi_r    <= {WIDTH{1'b0}};
            lo_r    <= {WIDTH{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            hi_r    <= hi_s;
            lo_r    <= lo_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: tb/tb_muldiv.sv
// Self-checking bench for muldiv: directed vector table, cancel/reset sequences,
// and randomized operations against an arithmetic reference model.
module tb_muldiv;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start, hassign, cancel;
    logic [1:0]  op;
    logic [31:0] srca, srcb;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;
    logic [31:0] hi_m, lo_m;

    muldiv #(.WIDTH(32), .MUL_CYCLES(3)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .hassign(hassign),
        .srca(srca), .srcb(srcb), .cancel(cancel),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        bit          poke;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] o, input logic s,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] hp, input logic [31:0] lp);
        longint p;
        int     sa, sb, q, r;
        case (o)
            OP_MTHI: return {a, lp};
            OP_MTLO: return {hp, a};
            OP_MULT: begin
                if (s) begin
                    p = longint'($signed(a)) * longint'($signed(b));
                    return p;
                end
                return {32'd0, a} * {32'd0, b};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                if (s) begin
                    sa = $signed(a);
                    sb = $signed(b);
                    q  = sa / sb;
                    r  = sa % sb;
                    return {32'(r), 32'(q)};
                end
                return {a % b, a / b};
            end
        endcase
    endfunction

    function automatic int exp_cycles(input logic [1:0] o);
        if (o == OP_MULT) return 3;
        if (o == OP_DIV) return 33;
        return 0;
    endfunction

    // Issue one request, measure busy length, check done pulse and HI/LO.
    task automatic run_op(input string nm, input logic [1:0] o, input logic s,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input bit poke);
        int cyc;
        start = 1'b1; op = o; hassign = s; srca = a; srcb = b;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (busy && cyc < 200) begin
            if (poke && cyc == 5) begin
                start = 1'b1; op = OP_MTLO; srca = 32'hDEAD_BEEF;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        chk({nm, " busy_cycles"}, 64'(cyc), 64'(exp_cycles(o)));
        chk({nm, " done"}, 64'(done), 64'd1);
        chk({nm, " hi"}, 64'(hi), 64'(ehi));
        chk({nm, " lo"}, 64'(lo), 64'(elo));
        hi_m = ehi;
        lo_m = elo;
        @(posedge clk); #1;
        chk({nm, " done_pulse_end"}, 64'(done), 64'd0);
    endtask

    initial begin
        logic [1:0]  ro;
        logic        rs;
        logic [31:0] ra, rb;
        logic [63:0] e;

        vecs[0]  = '{OP_MULT, 1'b1, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0};
        vecs[1]  = '{OP_MULT, 1'b0, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002, 32'hFFFF_FFFA, 1'b0};
        vecs[2]  = '{OP_DIV,  1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[3]  = '{OP_DIV,  1'b0, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 1'b0};
        vecs[4]  = '{OP_DIV,  1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b1};
        vecs[5]  = '{OP_DIV,  1'b0, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0};
        vecs[6]  = '{OP_DIV,  1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
        vecs[7]  = '{OP_DIV,  1'b1, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b0};
        vecs[8]  = '{OP_MULT, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
        vecs[9]  = '{OP_MULT, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[10] = '{OP_DIV,  1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};

        rst = 1'b1; start = 1'b0; op = OP_MULT; hassign = 1'b0;
        srca = 32'd0; srcb = 32'd0; cancel = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset hi", 64'(hi), 64'd0);
        chk("reset lo", 64'(lo), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        rst = 1'b0;
        hi_m = 32'd0; lo_m = 32'd0;

        for (int i = 0; i < 11; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].sgn, vecs[i].a, vecs[i].b,
                   vecs[i].hi, vecs[i].lo, vecs[i].poke);
        end

        // Cancel a divide at busy cycle 10: no done, HI/LO untouched.
        start = 1'b1; op = OP_DIV; hassign = 1'b0; srca = 32'd1000; srcb = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("cancel busy_before", 64'(busy), 64'd1);
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        chk("cancel busy", 64'(busy), 64'd0);
        chk("cancel done", 64'(done), 64'd0);
        chk("cancel hi", 64'(hi), 64'(hi_m));
        chk("cancel lo", 64'(lo), 64'(lo_m));
        @(posedge clk); #1;
        chk("cancel done_later", 64'(done), 64'd0);

        run_op("mthi", OP_MTHI, 1'b0, 32'h1234_5678, 32'd0, 32'h1234_5678, lo_m, 1'b0);

        // Start with cancel in the same cycle is dropped.
        start = 1'b1; cancel = 1'b1; op = OP_MTLO; srca = 32'hCAFE_F00D;
        @(posedge clk); #1;
        start = 1'b0; cancel = 1'b0;
        chk("drop lo", 64'(lo), 64'(lo_m));
        chk("drop done", 64'(done), 64'd0);

        // Reset in the middle of a multiply.
        start = 1'b1; op = OP_MULT; hassign = 1'b0; srca = 32'd5; srcb = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst hi", 64'(hi), 64'd0);
        chk("midrst lo", 64'(lo), 64'd0);
        chk("midrst busy", 64'(busy), 64'd0);
        chk("midrst done", 64'(done), 64'd0);
        rst = 1'b0;
        hi_m = 32'd0; lo_m = 32'd0;
        @(posedge clk); #1;
        chk("midrst busy_after", 64'(busy), 64'd0);

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 9);
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 9) == 0) ra = 32'h8000_0000;
            e = model(ro, rs, ra, rb, hi_m, lo_m);
            run_op($sformatf("rand%0d", i), ro, rs, ra, rb, e[63:32], e[31:0], 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv.md
# muldiv

Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers, sitting beside the ALU in the execute stage of the pipelined datapath. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from execute and runs multiplies and divides over several cycles. While an operation is in flight it raises `busy` so the hazard unit can stall dependent HI/LO reads. Operand width, multiply latency and signedness are generalised beyond the single-cycle ALU.

## Interface
Parameters:
- `WIDTH`, 32: operand, HI and LO width.
- `MUL_CYCLES`, 3: multiply latency in cycles, ≥1.

Ports:
- `clk`  in  1  the single clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request valid this cycle.
- `op`  in  2  00 MULT, 01 DIV, 10 MTHI, 11 MTLO.
- `hassign`  in  1  1 = signed (MULT/DIV), 0 = unsigned (MULTU/DIVU); ignored for MTHI/MTLO.
- `srca`  in  WIDTH  multiplicand / dividend / MTHI-MTLO source.
- `srcb`  in  WIDTH  multiplier / divisor.
- `cancel`  in  1  abort the in-flight operation (exception/flush).
- `busy`  out  1  registered; operation in flight.
- `done`  out  1  registered one-cycle pulse after HI/LO update.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- States: IDLE, MUL, DIV, FIX.
- IDLE + `start` + !`cancel`:
  - MTHI/MTLO: write `srca` to `hi`/`lo`. Stay in IDLE, `busy` stays 0, `done`=1 next cycle.
  - MULT: latch operands, go to MUL.
  - DIV: latch operands, go to DIV.
- MUL: full 2·WIDTH product, {HI,LO} = product. Signed products use two's complement. Counter runs MUL_CYCLES−1..0 and exits to IDLE at 0, writing HI/LO.
- DIV: radix-2 restoring divide on operand magnitudes, one quotient bit per cycle, WIDTH iterations, then FIX.
- FIX (one cycle): apply signs. Quotient truncates toward zero; remainder takes the dividend's sign. LO = quotient, HI = remainder. Return to IDLE.
- Divide by zero: LO = all ones, HI = `srca` as latched. Signed and unsigned behave the same.
- Signed overflow (most-negative / −1): LO = most-negative, HI = 0.
- `start` while `busy`=1 is ignored; the hazard unit guarantees this does not happen.
- `cancel` while busy: go to IDLE on the next edge, HI/LO unchanged, no `done`.
- `cancel` with `start` in the same cycle: the request is dropped.
- `rst` (including mid-operation): state IDLE, `hi`=`lo`=0, `busy`=0, `done`=0, counters 0.

## Timing
- Edge *t* samples `start`. `busy` is 1 from *t* through the edge that writes HI/LO, then 0.
- MULT: HI/LO written at edge *t*+MUL_CYCLES. `busy` high for MUL_CYCLES cycles; `done` high in the cycle after the write.
- DIV: HI/LO written at edge *t*+WIDTH+1 (33 for WIDTH=32). `busy` high for WIDTH+1 cycles.
- MTHI/MTLO: register written at edge *t*, `done` in the following cycle.
- Back-to-back: a new `start` is accepted in the first cycle `busy`=0, i.e. the same cycle `done`=1.
- `hi`/`lo` are direct register outputs with no combinational path from inputs.

## Structure
- Package `muldiv_pkg` holds the op encodings (`OP_MULT`, `OP_DIV`, `OP_MTHI`, `OP_MTLO`) and the state enum (IDLE/MUL/DIV/FIX).
- Sub-module `div_iter`: the restoring divider core.
  - Inputs: magnitudes plus a load strobe.
  - Per-cycle step: shifts out one quotient bit.
  - Outputs: unsigned quotient and remainder.
  - Sign handling and the zero/overflow special cases stay in `muldiv`.
- Multiplier: one `*` product followed by a MUL_CYCLES−1 register delay line, suitable for retiming.

## Test plan
All with WIDTH=32, MUL_CYCLES=3.
- MULT signed, 0xFFFFFFFE × 0x00000003 → HI=0xFFFFFFFF, LO=0xFFFFFFFA; `busy` high 3 cycles; `done` one cycle later.
- MULTU, same operands → HI=0x00000002, LO=0xFFFFFFFA.
- DIV signed, 0xFFFFFFF9 (−7) / 0x00000002 → LO=0xFFFFFFFD, HI=0xFFFFFFFF; `busy` exactly 33 cycles.
- DIVU 0x64 / 0 → LO=0xFFFFFFFF, HI=0x00000064.
- DIV signed 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0. A `start` issued mid-operation is ignored.
- Cancel and reset, in sequence:
  - Start DIV, assert `cancel` at busy cycle 10 → `busy` 0 next edge, no `done`, HI/LO keep prior values.
  - Then MTHI 0x12345678 → `hi`=0x12345678 after one edge, `done` pulse, `busy` never 1.
  - Then assert `rst` mid-MULT → all outputs 0.
